bcd_excess3_word_sequencer: RTL and testbench



---
 rtl/bcd_excess3_word_sequencer.sv | 114 +++++++++++
 tb/tb_bcd_excess3_word_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_excess3_word_sequencer.sv
// Word sequencer for the external serial BCD-to-Excess-3 Mealy converter: shifts a BCD word
// LSB-first through the converter and collects the result. Define BCD_CHECK_EN to flag nibbles > 9.
module bcd_excess3_word_sequencer #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_digits,
  output logic                  conv_B_in,
  input  logic                  conv_B_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_word,
  output logic                  out_err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t          state;
  logic [1:0]      ph;
  logic [W-1:0]    sreg;
  logic [W-1:0]    res;
  logic [CW-1:0]   bit_cnt;

  logic            accept;
  logic            last_bit;
  logic            release_word;

  // ph mirrors the converter's digit position: ph == 0 exactly when it sits in S_0.
  assign in_ready     = (state == IDLE) && (ph == 2'd3);
  assign accept       = in_valid && in_ready;
  assign last_bit     = (state == SHIFT) && (bit_cnt == CW'(W - 1));
  assign release_word = out_valid && out_ready;

  // The converter is Mealy: conv_B_out answers this very bit within the same cycle.
  assign conv_B_in = (state == SHIFT) && sreg[0];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let later statements see half-updated state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ph        <= 2'd0;
      sreg      <= '0;
      res       <= '0;
      bit_cnt   <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
    end else begin
      ph <= ph + 2'd1;
      case (state)
        IDLE: begin
          if (accept) begin
            sreg    <= in_digits;
            res     <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          sreg    <= sreg >> 1;
          res     <= {conv_B_out, res[W-1:1]};
          bit_cnt <= bit_cnt + CW'(1);
          if (last_bit) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            out_word  <= {conv_B_out, res[W-1:1]};
          end
        end
        HOLD: begin
          if (release_word) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BCD_CHECK_EN
  logic err_q;

  function automatic logic any_non_bcd(input logic [W-1:0] word);
    logic flag;
    flag = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      flag |= (word[4*k +: 4] > 4'd9);
    end
    return flag;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= any_non_bcd(in_digits);
    end else if (release_word) begin
      err_q <= 1'b0;
    end
  end

  // The flag is latched at acceptance but only reported alongside the finished word.
  assign out_err = err_q && out_valid;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_excess3_word_sequencer.sv
// Bench for bcd_excess3_word_sequencer (DIGITS=4) with a behavioural model of the serial
// Excess-3 converter: a serial adder of 4'b0011 restarting every 4 clocks from reset.
module tb_bcd_excess3_word_sequencer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_digits;
  logic        conv_B_in;
  logic        conv_B_out;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_word;
  logic        out_err;

  int n_vec = 0;
  int n_err = 0;

  bcd_excess3_word_sequencer #(.DIGITS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_digits  (in_digits),
    .conv_B_in  (conv_B_in),
    .conv_B_out (conv_B_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Converter model: cph is its position in the digit (S_0 when cph == 0).
  logic [1:0] cph;
  logic       carry;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cph   <= 2'd0;
      carry <= 1'b0;
    end else begin
      cph <= cph + 2'd1;
      case (cph)
        2'd0:    carry <= conv_B_in;
        2'd1:    carry <= conv_B_in | carry;
        2'd2:    carry <= conv_B_in & carry;
        default: carry <= 1'b0;
      endcase
    end
  end

  always_comb begin
    conv_B_out = 1'b0;
    case (cph)
      2'd0:    conv_B_out = ~conv_B_in;
      2'd1:    conv_B_out = ~(conv_B_in ^ carry);
      default: conv_B_out = conv_B_in ^ carry;
    endcase
  end

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp_word;
    logic        exp_err;
    bit          chk_word;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, {15'b0, act}, {15'b0, exp});
  endtask

  // Called at a falling edge; returns at the falling edge just after the accepting edge.
  task automatic accept_word(input logic [15:0] din);
    int guard = 0;
    in_digits = din;
    in_valid  = 1'b1;
    while (!in_ready && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    check_bit("accept_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check_bit("busy_ready_low", in_ready, 1'b0);
  endtask

  // Counting the accepting edge as edge 1, out_valid must first be seen after edge 17.
  task automatic wait_valid(input string name);
    int lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 16'(lat), 16'd17);
  endtask

  task automatic check_result(input string name, input logic [15:0] ew, input logic ee,
                              input bit chk_word);
    check_bit({name, "_valid"}, out_valid, 1'b1);
    if (chk_word) check({name, "_word"}, out_word, ew);
    check_bit({name, "_err"}, out_err, ee);
  endtask

  task automatic ack(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_bit({name, "_valid_drop"}, out_valid, 1'b0);
    check_bit({name, "_err_drop"}, out_err, 1'b0);
  endtask

  task automatic collect(input string name, input logic [15:0] ew, input logic ee,
                         input bit chk_word);
    wait_valid(name);
    check_result(name, ew, ee, chk_word);
    ack(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic err_exp;
`ifdef BCD_CHECK_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    vecs[0] = '{16'h1234, 16'h4567, 1'b0, 1'b1};
    vecs[1] = '{16'h0000, 16'h3333, 1'b0, 1'b1};
    vecs[2] = '{16'h9999, 16'hCCCC, 1'b0, 1'b1};
    vecs[3] = '{16'h5080, 16'h83B3, 1'b0, 1'b1};
    vecs[4] = '{16'h12A4, 16'h0000, err_exp, 1'b0};
    vecs[5] = '{16'h0001, 16'h3334, 1'b0, 1'b1};

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_digits = '0;
    out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check_bit("rst_in_ready", in_ready, 1'b0);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check("rst_out_word", out_word, 16'h0000);
    check_bit("rst_out_err", out_err, 1'b0);
    check_bit("rst_conv_B_in", conv_B_in, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_bit("idle_ph1_ready", in_ready, 1'b0);

    for (int i = 0; i < 6; i++) begin
      accept_word(vecs[i].din);
      collect($sformatf("vec%0d", i), vecs[i].exp_word, vecs[i].exp_err, vecs[i].chk_word);
    end

    // Phase alignment: request raised in a ph == 1 cycle is accepted at the end of ph == 3.
    begin
      int guard = 0;
      while (cph != 2'd1 && guard < 8) begin
        @(negedge clk);
        guard++;
      end
      check("phase_find_ph1", {14'b0, cph}, 16'd1);
      in_digits = 16'h2468;
      in_valid  = 1'b1;
      check_bit("phase_ready_ph1", in_ready, 1'b0);
      @(negedge clk);
      check_bit("phase_ready_ph2", in_ready, 1'b0);
      @(negedge clk);
      check_bit("phase_ready_ph3", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      check_bit("phase_ready_shift", in_ready, 1'b0);
      check("phase_conv_s0", {14'b0, cph}, 16'd0);
      collect("phase", 16'h579B, 1'b0, 1'b1);
    end

    // Backpressure: stalled HOLD keeps the word; a pending request waits for the handshake.
    accept_word(16'h1234);
    wait_valid("bp");
    in_digits = 16'h0001;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_bit("bp_valid", out_valid, 1'b1);
      check("bp_word", out_word, 16'h4567);
      check_bit("bp_in_ready", in_ready, 1'b0);
    end
    ack("bp");
    accept_word(16'h0001);
    out_ready = 1'b1;
    wait_valid("early_ready");
    check_result("early_ready", 16'h3334, 1'b0, 1'b1);
    ack("early_ready");

    // Reset during SHIFT bit 6 clears everything at once.
    accept_word(16'h1264);
    repeat (6) @(negedge clk);
    check_bit("mid_bit6", conv_B_in, 1'b1);
    reset = 1'b0;
    #1;
    check_bit("mid_rst_valid", out_valid, 1'b0);
    check_bit("mid_rst_ready", in_ready, 1'b0);
    check_bit("mid_rst_conv", conv_B_in, 1'b0);
    check("mid_rst_word", out_word, 16'h0000);
    check_bit("mid_rst_err", out_err, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    accept_word(16'h0042);
    collect("after_rst", 16'h3375, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
